// File: rtl/otter_fetch_unit_pkg.sv
// Shared types and constants for the OTTER fetch stage.
package otter_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_S_BOOT,
    FETCH_S_FETCH,
    FETCH_S_FULL
  } fetch_state_e;

  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/otter_fetch_fifo.sv
// Synchronous FIFO with flush; used for the PC tag queue and the instruction buffer.
module otter_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER program counter and instruction fetch stage with redirect squashing.
// Optional misaligned-redirect trap: define OTTER_FETCH_MISALIGN_TRAP_EN.
module otter_fetch_unit
  import otter_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
  ,
  output logic        o_fetch_misalign,
  output logic [31:0] o_fetch_badaddr
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_next;
  logic [CW-1:0] discard;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] tag_count;
  logic [CW:0]   occupancy;
  logic [31:0]   tag_pc;
  logic [63:0]   buf_head;
  logic          tag_full, tag_empty, buf_full, buf_empty;
  logic          halted, credit, req_pre, accept, pop, rsp_keep, rsp_drop;
  logic          unused_fifo;

  // Credits count both in-flight requests and buffered words; a pop this
  // cycle frees a slot early so a zero-wait memory streams one word per cycle.
  assign pop       = !buf_empty && i_inst_ready;
  assign occupancy = {1'b0, outstanding} + {1'b0, buf_count} - (CW+1)'(pop);
  assign credit    = occupancy < DEPTH_W;
  assign req_pre   = (state == FETCH_S_FETCH) && credit && !halted;
  assign accept    = o_imem_req && i_imem_gnt;
  assign rsp_drop  = i_imem_rvalid && (discard != '0);
  assign rsp_keep  = i_imem_rvalid && (discard == '0);
  assign out_next  = outstanding + CW'(accept) - CW'(i_imem_rvalid);

  assign o_imem_req   = req_pre && !i_redirect;
  assign o_imem_addr  = fetch_pc;
  assign o_inst_valid = !buf_empty;
  assign o_inst       = buf_empty ? INST_NOP : buf_head[63:32];
  assign o_inst_pc    = buf_empty ? '0 : buf_head[31:0];
  assign unused_fifo  = &{1'b0, tag_full, tag_empty, buf_full, tag_count};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= FETCH_S_BOOT;
      fetch_pc    <= RESET_VEC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (i_redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        state    <= FETCH_S_FETCH;
        fetch_pc <= i_redirect_addr & PC_ALIGN_MASK;
        discard  <= out_next;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + PC_STEP;
        if (rsp_drop) discard  <= discard - CW'(1);
        case (state)
          FETCH_S_BOOT:  state <= FETCH_S_FETCH;
          FETCH_S_FETCH: if (!credit) state <= FETCH_S_FULL;
          FETCH_S_FULL:  if (credit)  state <= FETCH_S_FETCH;
          default:       state <= FETCH_S_BOOT;
        endcase
      end
    end
  end

`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
  logic [31:0] badaddr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      halted  <= 1'b0;
      badaddr <= '0;
    end else if (i_redirect) begin
      halted  <= |i_redirect_addr[1:0];
      badaddr <= (|i_redirect_addr[1:0]) ? i_redirect_addr : '0;
    end
  end

  assign o_fetch_misalign = halted;
  assign o_fetch_badaddr  = badaddr;
`else
  assign halted = 1'b0;
`endif

  otter_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .flush     (i_redirect),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .pop_data  (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  otter_fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .flush     (i_redirect),
    .push      (rsp_keep),
    .push_data ({i_imem_rdata, tag_pc}),
    .pop       (pop),
    .pop_data  (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

endmodule
